i2c_reg_arbiter: RTL and testbench

Owns the register bank behind the I2C slave register interface and shares it with a local on-chip requester. The I2C side gets combinational read data and absolute write priority, because the slave has no back-pressure. The local side uses a req/gnt handshake and can optionally be locked out for a whole I2C transaction. The block also reports each completed I2C write burst (first address, count) so downstream logic can reload its configuration.

---
 rtl/i2c_reg_arbiter.sv | 109 ++++++++++
 tb/tb_i2c_reg_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_arbiter.sv
// rtl/i2c_reg_arbiter.sv - register bank shared between I2C slave and local requester
// I2C writes always win; local side waits via req/gnt; completed I2C write bursts are reported.
module i2c_reg_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int LOCK_ON_BUSY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_write_en,
  input  logic [ADDR_WIDTH-1:0] i2c_reg_addr,
  input  logic [DATA_WIDTH-1:0] i2c_data_out,
  output logic [DATA_WIDTH-1:0] i2c_data_in,
  input  logic                  i2c_busy,
  input  logic                  i2c_done,
  input  logic                  loc_req,
  input  logic                  loc_we,
  input  logic [ADDR_WIDTH-1:0] loc_addr,
  input  logic [DATA_WIDTH-1:0] loc_wdata,
  output logic                  loc_gnt,
  output logic [DATA_WIDTH-1:0] loc_rdata,
  output logic                  upd_valid,
  output logic [ADDR_WIDTH-1:0] upd_addr_first,
  output logic [7:0]            upd_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];
  logic [7:0]              burst_cnt;
  logic [ADDR_WIDTH-1:0]   burst_first;
  logic [7:0]              cnt_next;
  logic [ADDR_WIDTH-1:0]   first_next;
  logic                    accept;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign i2c_data_in = in_range(i2c_reg_addr) ? regs[i2c_reg_addr[IDX_W-1:0]] : '0;

  // The slave cannot stall, so any I2C write cycle blocks local acceptance.
  assign accept = loc_req && !i2c_write_en && !((LOCK_ON_BUSY != 0) && i2c_busy);

  // A write landing in the same cycle as done still belongs to the reported burst.
  assign cnt_next   = i2c_write_en ? sat_inc(burst_cnt) : burst_cnt;
  assign first_next = (i2c_write_en && burst_cnt == 8'd0) ? i2c_reg_addr : burst_first;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      loc_gnt        <= 1'b0;
      loc_rdata      <= '0;
      upd_valid      <= 1'b0;
      upd_addr_first <= '0;
      upd_count      <= 8'd0;
      burst_cnt      <= 8'd0;
      burst_first    <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      upd_valid <= 1'b0;

      if (i2c_write_en) begin
        if (in_range(i2c_reg_addr)) regs[i2c_reg_addr[IDX_W-1:0]] <= i2c_data_out;
        if (burst_cnt == 8'd0) burst_first <= i2c_reg_addr;
        burst_cnt <= sat_inc(burst_cnt);
      end

      if (i2c_done && cnt_next != 8'd0) begin
        upd_valid      <= 1'b1;
        upd_addr_first <= first_next;
        upd_count      <= cnt_next;
        burst_cnt      <= 8'd0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (loc_we) begin
              if (in_range(loc_addr)) regs[loc_addr[IDX_W-1:0]] <= loc_wdata;
            end else begin
              loc_rdata <= in_range(loc_addr) ? regs[loc_addr[IDX_W-1:0]] : '0;
            end
            loc_gnt <= 1'b1;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          loc_gnt <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          loc_gnt <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// tb/tb_i2c_reg_arbiter.sv - directed self-checking bench for i2c_reg_arbiter
// Two instances share stimulus: full-depth and DEPTH=16 for out-of-range behaviour.
module tb_i2c_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2c_write_en, i2c_busy, i2c_done;
  logic [7:0]  i2c_reg_addr, loc_addr;
  logic [15:0] i2c_data_out, loc_wdata;
  logic        loc_req, loc_we;
  logic [15:0] i2c_data_in, loc_rdata, s_i2c_data_in, s_loc_rdata;
  logic        loc_gnt, upd_valid, s_loc_gnt, s_upd_valid;
  logic [7:0]  upd_addr_first, upd_count, s_upd_addr_first, s_upd_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2c_reg_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .LOCK_ON_BUSY(1)) dut (
    .clk(clk), .reset(reset), .i2c_write_en(i2c_write_en), .i2c_reg_addr(i2c_reg_addr),
    .i2c_data_out(i2c_data_out), .i2c_data_in(i2c_data_in), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .upd_valid(upd_valid),
    .upd_addr_first(upd_addr_first), .upd_count(upd_count)
  );

  i2c_reg_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(16), .LOCK_ON_BUSY(1)) dut_small (
    .clk(clk), .reset(reset), .i2c_write_en(i2c_write_en), .i2c_reg_addr(i2c_reg_addr),
    .i2c_data_out(i2c_data_out), .i2c_data_in(s_i2c_data_in), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_gnt(s_loc_gnt), .loc_rdata(s_loc_rdata), .upd_valid(s_upd_valid),
    .upd_addr_first(s_upd_addr_first), .upd_count(s_upd_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and wait (bounded) for gnt; leaves the DUT in its grant cycle.
  task automatic loc_access(input logic we, input logic [7:0] a, input logic [15:0] d, output int lat);
    loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!loc_gnt && lat < 20);
    loc_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i2c_write_en = 1'b0; i2c_reg_addr = 8'h00; i2c_data_out = 16'h0000;
    i2c_busy = 1'b0; i2c_done = 1'b0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = 8'h00; loc_wdata = 16'h0000;
    repeat (3) tick();
    tests++; if ({loc_gnt, upd_valid, s_loc_gnt, s_upd_valid} !== 4'b0000) begin fails++; $display("FAIL reset_pulses: got %b required 0000", {loc_gnt, upd_valid, s_loc_gnt, s_upd_valid}); end
    tests++; if ({loc_rdata, upd_addr_first, upd_count, i2c_data_in} !== 48'h0) begin fails++; $display("FAIL reset_values: got %h required 0", {loc_rdata, upd_addr_first, upd_count, i2c_data_in}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_local_read();
    int lat;
    loc_access(1'b0, 8'h10, 16'h0, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL read_latency: got %0d required 1", lat); end
    tests++; if (loc_rdata !== 16'h0000) begin fails++; $display("FAIL read_0x10: got %h required 0000", loc_rdata); end
    tick();
    tests++; if (loc_gnt !== 1'b0) begin fails++; $display("FAIL gnt_one_cycle: got %b required 0", loc_gnt); end
  endtask

  task automatic test_local_write();
    int lat;
    loc_access(1'b1, 8'h05, 16'hBEEF, lat);
    tick();
    i2c_reg_addr = 8'h05;
    #1;
    tests++; if (i2c_data_in !== 16'hBEEF) begin fails++; $display("FAIL i2c_read_0x05: got %h required beef", i2c_data_in); end
    loc_access(1'b0, 8'h05, 16'h0, lat);
    tests++; if (loc_rdata !== 16'hBEEF) begin fails++; $display("FAIL loc_read_0x05: got %h required beef", loc_rdata); end
    tick();
  endtask

  task automatic test_collision();
    i2c_write_en = 1'b1; i2c_reg_addr = 8'h20; i2c_data_out = 16'h1234;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h20;
    tick();
    i2c_write_en = 1'b0;
    tests++; if (loc_gnt !== 1'b0) begin fails++; $display("FAIL collide_defer: got gnt %b required 0", loc_gnt); end
    tick();
    tests++; if ({loc_gnt, loc_rdata} !== {1'b1, 16'h1234}) begin fails++; $display("FAIL collide_read: got %b/%h required 1/1234", loc_gnt, loc_rdata); end
    loc_req = 1'b0;
    tick();
    // same-cycle writes to one address: deferred local write lands last
    i2c_write_en = 1'b1; i2c_reg_addr = 8'h21; i2c_data_out = 16'h1111;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h21; loc_wdata = 16'h2222;
    tick();
    i2c_write_en = 1'b0;
    tick();
    loc_req = 1'b0;
    tick();
    tests++; if (i2c_data_in !== 16'h2222) begin fails++; $display("FAIL collide_write: got %h required 2222", i2c_data_in); end
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    tests++; if ({upd_valid, upd_addr_first, upd_count} !== {1'b1, 8'h20, 8'd2}) begin fails++; $display("FAIL collide_burst: got %b/%h/%0d required 1/20/2", upd_valid, upd_addr_first, upd_count); end
    tick();
  endtask

  task automatic test_lock();
    int seen = 0;
    i2c_busy = 1'b1;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h05;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (loc_gnt) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL lock_hold: got %0d gnts required 0", seen); end
    i2c_busy = 1'b0;
    tick();
    tests++; if ({loc_gnt, loc_rdata} !== {1'b1, 16'hBEEF}) begin fails++; $display("FAIL lock_release: got %b/%h required 1/beef", loc_gnt, loc_rdata); end
    loc_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int gnts = 0;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h05;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (loc_gnt) gnts++;
    end
    loc_req = 1'b0;
    tests++; if (gnts !== 3) begin fails++; $display("FAIL back_to_back: got %0d gnts required 3", gnts); end
    tick();
  endtask

  task automatic test_burst();
    for (int i = 0; i < 3; i++) begin
      i2c_write_en = 1'b1; i2c_reg_addr = 8'h30 + 8'(i); i2c_data_out = 16'hA000 + 16'(i);
      tick();
    end
    i2c_write_en = 1'b0;
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    tests++; if ({upd_valid, upd_addr_first, upd_count} !== {1'b1, 8'h30, 8'd3}) begin fails++; $display("FAIL burst_report: got %b/%h/%0d required 1/30/3", upd_valid, upd_addr_first, upd_count); end
    tick();
    tests++; if ({upd_valid, upd_addr_first, upd_count} !== {1'b0, 8'h30, 8'd3}) begin fails++; $display("FAIL burst_hold: got %b/%h/%0d required 0/30/3", upd_valid, upd_addr_first, upd_count); end
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL read_only_done: got %b required 0", upd_valid); end
    i2c_write_en = 1'b1; i2c_reg_addr = 8'h50; i2c_data_out = 16'h5555;
    tick();
    i2c_reg_addr = 8'h51; i2c_done = 1'b1;
    tick();
    i2c_write_en = 1'b0; i2c_done = 1'b0;
    tests++; if ({upd_valid, upd_addr_first, upd_count} !== {1'b1, 8'h50, 8'd2}) begin fails++; $display("FAIL write_with_done: got %b/%h/%0d required 1/50/2", upd_valid, upd_addr_first, upd_count); end
    i2c_reg_addr = 8'h31;
    tick();
    tests++; if (i2c_data_in !== 16'hA001) begin fails++; $display("FAIL burst_data: got %h required a001", i2c_data_in); end
  endtask

  task automatic test_small_depth();
    int lat;
    loc_access(1'b1, 8'h40, 16'hFFFF, lat);
    tick();
    loc_access(1'b0, 8'h40, 16'h0, lat);
    tests++; if ({s_loc_gnt, s_loc_rdata, loc_rdata} !== {1'b1, 16'h0000, 16'hFFFF}) begin fails++; $display("FAIL oor_loc_read: got %b/%h/%h required 1/0000/ffff", s_loc_gnt, s_loc_rdata, loc_rdata); end
    tick();
    i2c_reg_addr = 8'h40;
    #1;
    tests++; if ({s_i2c_data_in, i2c_data_in} !== {16'h0000, 16'hFFFF}) begin fails++; $display("FAIL oor_i2c_read: got %h/%h required 0000/ffff", s_i2c_data_in, i2c_data_in); end
    i2c_write_en = 1'b1; i2c_reg_addr = 8'h03; i2c_data_out = 16'h0C0C;
    tick();
    i2c_write_en = 1'b0;
    tests++; if (s_i2c_data_in !== 16'h0C0C) begin fails++; $display("FAIL small_in_range: got %h required 0c0c", s_i2c_data_in); end
  endtask

  task automatic test_reset_in_grant();
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h03;
    tick();
    tests++; if (loc_gnt !== 1'b1) begin fails++; $display("FAIL pre_reset_gnt: got %b required 1", loc_gnt); end
    reset = 1'b0;
    tick();
    tests++; if ({loc_gnt, s_loc_gnt} !== 2'b00) begin fails++; $display("FAIL reset_in_grant: got %b required 00", {loc_gnt, s_loc_gnt}); end
    tick();
    tests++; if ({loc_gnt, loc_rdata, i2c_data_in, upd_count} !== {1'b0, 16'h0, 16'h0, 8'h0}) begin fails++; $display("FAIL reset_clears: got %b/%h/%h/%0d required 0/0/0/0", loc_gnt, loc_rdata, i2c_data_in, upd_count); end
    loc_req = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_local_read();
    test_local_write();
    test_collision();
    test_lock();
    test_back_to_back();
    test_burst();
    test_small_depth();
    test_reset_in_grant();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
